// File: rtl/ssram_arbiter.sv
// ssram_arbiter: shares one single-port synchronous SRAM between two
// req/gnt requesters, with round-robin or fixed-priority arbitration and a
// bounded lock that lets one port hold the SRAM for back-to-back accesses.
module ssram_arbiter #(
    parameter int unsigned AW        = 12,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_LOCK  = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          p0_req,
    input  logic          p0_lock,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [3:0]    p0_wb,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic          p1_lock,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [3:0]    p1_wb,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic [AW-1:0] sram_addr,
    output logic          sram_en,
    output logic          sram_we,
    output logic [3:0]    sram_wb,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e   state_q, state_d;
    logic          lock_own_q, lock_own_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          last_owner_q, last_owner_d;
    logic          p0_rvalid_d, p1_rvalid_d;

    logic          any_gnt;
    logic          lock_hit;
    logic          win;
    logic          win_we;
    logic          win_lock;
    logic [CW:0]   cnt_inc;

    // Arbitration: lock owner first, then a lone requester, then the tie rule
    always_comb begin
        any_gnt  = p0_req | p1_req;
        lock_hit = (state_q == ST_LOCKED) && (lock_own_q ? p1_req : p0_req)
                   && (lock_cnt_q < CW'(MAX_LOCK));
        win      = 1'b0;
        if (lock_hit) begin
            win = lock_own_q;
        end else if (p0_req && p1_req) begin
            win = (PRIO_MODE == 0) ? ~last_owner_q : 1'b0;
        end else begin
            win = p1_req;
        end
        win_we   = win ? p1_we   : p0_we;
        win_lock = win ? p1_lock : p0_lock;
    end

    // SRAM command mux and combinational grants
    assign p0_gnt    = any_gnt & ~win;
    assign p1_gnt    = any_gnt & win;
    assign sram_en   = any_gnt;
    assign sram_we   = any_gnt & win_we;
    assign sram_wb   = (any_gnt && win_we) ? (win ? p1_wb : p0_wb) : 4'h0;
    assign sram_addr = win ? p1_addr : p0_addr;
    assign sram_din  = win ? p1_wdata : p0_wdata;

    // Read data is broadcast; only rvalid tells each port it is theirs
    assign p0_rdata  = sram_dout;
    assign p1_rdata  = sram_dout;

    assign cnt_inc   = {1'b0, lock_cnt_q} + (CW+1)'(1);

    // Next-state: lock FSM, round-robin pointer and read-return tracking
    always_comb begin
        state_d      = state_q;
        lock_own_d   = lock_own_q;
        lock_cnt_d   = lock_cnt_q;
        last_owner_d = last_owner_q;
        p0_rvalid_d  = 1'b0;
        p1_rvalid_d  = 1'b0;

        if (any_gnt) begin
            last_owner_d = win;
            p0_rvalid_d  = ~win_we & ~win;
            p1_rvalid_d  = ~win_we & win;
        end

        if ((state_q == ST_LOCKED) && any_gnt && (win == lock_own_q)) begin
            // Owner continues only while it keeps lock and is under the cap
            if (win_lock && (cnt_inc < (CW+1)'(MAX_LOCK))) begin
                lock_cnt_d = CW'(cnt_inc);
            end else begin
                state_d    = ST_UNLOCKED;
                lock_cnt_d = '0;
            end
        end else if (any_gnt && win_lock && (MAX_LOCK > 1)) begin
            state_d    = ST_LOCKED;
            lock_own_d = win;
            lock_cnt_d = CW'(1);
        end else begin
            state_d    = ST_UNLOCKED;
            lock_cnt_d = '0;
        end
    end

    // State register; reset drops any pending read return
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_UNLOCKED;
            lock_own_q   <= 1'b0;
            lock_cnt_q   <= '0;
            last_owner_q <= 1'b1;
            p0_rvalid    <= 1'b0;
            p1_rvalid    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_own_q   <= lock_own_d;
            lock_cnt_q   <= lock_cnt_d;
            last_owner_q <= last_owner_d;
            p0_rvalid    <= p0_rvalid_d;
            p1_rvalid    <= p1_rvalid_d;
        end
    end

endmodule

// File: tb/tb_ssram_arbiter.sv
// Bench for ssram_arbiter: round-robin/lock instance plus a fixed-priority
// instance sharing the same requester stimulus, a behavioural SRAM, and a
// read-return scoreboard.
module tb_ssram_arbiter;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        boot    = 1'b1;

    logic        p0_req, p0_lock, p0_we, p1_req, p1_lock, p1_we;
    logic [11:0] p0_addr, p1_addr;
    logic [3:0]  p0_wb, p1_wb;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [11:0] sram_addr;
    logic        sram_en, sram_we;
    logic [3:0]  sram_wb;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    logic        fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_sram_din;
    logic [11:0] fp_sram_addr;
    logic        fp_sram_en, fp_sram_we;
    logic [3:0]  fp_sram_wb;

    always #5 HCLK = ~HCLK;

    ssram_arbiter #(.AW(12), .PRIO_MODE(0), .MAX_LOCK(4)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wb(p0_wb), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wb(p1_wb), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_we(sram_we),
        .sram_wb(sram_wb), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    ssram_arbiter #(.AW(12), .PRIO_MODE(1), .MAX_LOCK(4)) u_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wb(p0_wb), .p0_wdata(p0_wdata), .p0_gnt(fp_p0_gnt),
        .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wb(p1_wb), .p1_wdata(p1_wdata), .p1_gnt(fp_p1_gnt),
        .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
        .sram_addr(fp_sram_addr), .sram_en(fp_sram_en), .sram_we(fp_sram_we),
        .sram_wb(fp_sram_wb), .sram_din(fp_sram_din), .sram_dout(sram_dout)
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == 12'h020) ? 32'h1122_3344 : (32'hA500_0000 | 32'(a));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] wb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM: unwritten words read back init_val(addr)
    logic [31:0] mem     [0:4095];
    logic        wr_flag [0:4095];
    logic [31:0] ref_mem [0:4095];

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            if (boot) for (int i = 0; i < 4096; i++) wr_flag[i] <= 1'b0;
        end else if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr]     <= merge(wr_flag[sram_addr] ? mem[sram_addr] : init_val(sram_addr),
                                            sram_din, sram_wb);
                wr_flag[sram_addr] <= 1'b1;
            end else begin
                sram_dout <= wr_flag[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
            end
        end
    end

    typedef struct packed {
        logic [2:0]  c0;   // {req, lock, we}
        logic [11:0] a0;
        logic [3:0]  b0;
        logic [31:0] d0;
        logic [2:0]  c1;
        logic [11:0] a1;
        logic [3:0]  b1;
        logic [31:0] d1;
        logic [4:0]  ex;   // {g0, g1, check_fp, fp_g0, fp_g1}
    } vec_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } rd_t;

    vec_t tbl[$];
    rd_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic [2:0] c0, input logic [11:0] a0, input logic [3:0] b0,
                                input logic [31:0] d0, input logic [2:0] c1, input logic [11:0] a1,
                                input logic [3:0] b1, input logic [31:0] d1, input logic [4:0] ex);
        vec_t v;
        v.c0 = c0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
        v.c1 = c1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        v.ex = ex;
        return v;
    endfunction

    function automatic vec_t idle_v();
        return mk(3'b000, 12'h0, 4'h0, 32'h0, 3'b000, 12'h0, 4'h0, 32'h0, 5'b00000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare read returns against the scoreboard entry from the previous grant
    task automatic check_rvalid();
        rd_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid", 32'({p1_rvalid, p0_rvalid}), e.port ? 32'd2 : 32'd1);
            chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
        end else begin
            chk("rvalid_idle", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        end
    endtask

    task automatic drive(input vec_t t);
        {p0_req, p0_lock, p0_we} = t.c0;
        p0_addr = t.a0; p0_wb = t.b0; p0_wdata = t.d0;
        {p1_req, p1_lock, p1_we} = t.c1;
        p1_addr = t.a1; p1_wb = t.b1; p1_wdata = t.d1;
    endtask

    // One clock of stimulus: check returns, drive, check grant and SRAM command
    task automatic step(input vec_t t);
        logic        g0, g1, port, we;
        logic [11:0] a;
        logic [3:0]  wb;
        logic [31:0] d;
        rd_t         e;
        @(posedge HCLK); #1;
        check_rvalid();
        drive(t);
        #1;
        {g0, g1} = t.ex[4:3];
        chk("gnt", 32'({p1_gnt, p0_gnt}), 32'({g1, g0}));
        chk("sram_en", 32'(sram_en), 32'(g0 | g1));
        if (t.ex[2]) chk("fp_gnt", 32'({fp_p1_gnt, fp_p0_gnt}), 32'(t.ex[1:0] == 2'b10 ? 2'b01 : t.ex[1:0] == 2'b01 ? 2'b10 : 2'b00));
        if (g0 | g1) begin
            port = g1;
            we   = port ? t.c1[0] : t.c0[0];
            a    = port ? t.a1 : t.a0;
            wb   = port ? t.b1 : t.b0;
            d    = port ? t.d1 : t.d0;
            chk("sram_addr", 32'(sram_addr), 32'(a));
            chk("sram_we", 32'(sram_we), 32'(we));
            chk("sram_wb", 32'(sram_wb), we ? 32'(wb) : 32'd0);
            if (we) begin
                chk("sram_din", sram_din, d);
                ref_mem[a] = merge(ref_mem[a], d, wb);
            end else begin
                e.port = port;
                e.data = ref_mem[a];
                exp_q.push_back(e);
            end
        end else begin
            chk("sram_we_idle", 32'({sram_we, sram_wb}), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        drive(idle_v());

        // Round-robin from reset: p0 first, then alternate; waiting port holds addr
        tbl.push_back(mk(3'b100, 12'h100, 4'h0, 32'h0, 3'b100, 12'h200, 4'h0, 32'h0, 5'b10000));
        tbl.push_back(mk(3'b100, 12'h101, 4'h0, 32'h0, 3'b100, 12'h200, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(mk(3'b100, 12'h101, 4'h0, 32'h0, 3'b100, 12'h201, 4'h0, 32'h0, 5'b10000));
        tbl.push_back(mk(3'b100, 12'h102, 4'h0, 32'h0, 3'b100, 12'h201, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(idle_v());
        // Single port write then read-back
        tbl.push_back(mk(3'b101, 12'h010, 4'hF, 32'hDEAD_BEEF, 3'b000, 12'h0, 4'h0, 32'h0, 5'b10000));
        tbl.push_back(mk(3'b100, 12'h010, 4'h0, 32'h0, 3'b000, 12'h0, 4'h0, 32'h0, 5'b10000));
        tbl.push_back(idle_v());
        // Byte write on p1 into 0x11223344, then read
        tbl.push_back(mk(3'b000, 12'h0, 4'h0, 32'h0, 3'b101, 12'h020, 4'b0100, 32'h00AB_0000, 5'b01000));
        tbl.push_back(mk(3'b000, 12'h0, 4'h0, 32'h0, 3'b100, 12'h020, 4'hF, 32'hFFFF_FFFF, 5'b01000));
        tbl.push_back(idle_v());
        // Lock with MAX_LOCK=4: p1 x4, forced release, p0 once, p1 resumes
        tbl.push_back(mk(3'b000, 12'h0, 4'h0, 32'h0, 3'b110, 12'h300, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(mk(3'b100, 12'h110, 4'h0, 32'h0, 3'b110, 12'h301, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(mk(3'b100, 12'h110, 4'h0, 32'h0, 3'b110, 12'h302, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(mk(3'b100, 12'h110, 4'h0, 32'h0, 3'b110, 12'h303, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(mk(3'b100, 12'h110, 4'h0, 32'h0, 3'b110, 12'h304, 4'h0, 32'h0, 5'b10000));
        tbl.push_back(mk(3'b100, 12'h111, 4'h0, 32'h0, 3'b110, 12'h304, 4'h0, 32'h0, 5'b01000));
        tbl.push_back(idle_v());
        // Fixed priority instance: p0 always wins, p1 granted as soon as p0 drops
        tbl.push_back(mk(3'b100, 12'h120, 4'h0, 32'h0, 3'b100, 12'h220, 4'h0, 32'h0, 5'b10110));
        tbl.push_back(mk(3'b100, 12'h121, 4'h0, 32'h0, 3'b100, 12'h220, 4'h0, 32'h0, 5'b01110));
        tbl.push_back(mk(3'b100, 12'h122, 4'h0, 32'h0, 3'b100, 12'h221, 4'h0, 32'h0, 5'b10110));
        tbl.push_back(mk(3'b000, 12'h0, 4'h0, 32'h0, 3'b100, 12'h221, 4'h0, 32'h0, 5'b01101));
        tbl.push_back(idle_v());

        // Reset state
        #1;
        chk("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        chk("rst_idle_cmd", 32'({p1_gnt, p0_gnt, sram_en, sram_we, sram_wb}), 32'd0);
        repeat (3) @(posedge HCLK);
        @(negedge HRESETn or negedge HCLK);
        HRESETn = 1'b1;
        boot    = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset in the cycle after a p0 read grant drops the return
        step(mk(3'b100, 12'h010, 4'h0, 32'h0, 3'b000, 12'h0, 4'h0, 32'h0, 5'b10000));
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        drive(idle_v());
        #1;
        chk("rst_drop_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        // First tie after reset goes to p0
        step(mk(3'b100, 12'h040, 4'h0, 32'h0, 3'b100, 12'h041, 4'h0, 32'h0, 5'b10000));
        step(idle_v());
        step(idle_v());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
